// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: boot-time register loader for the TVP5147M1 decoder.
// Walks a table held in a synchronous ROM. Each record is a slave address
// byte, a pair count, then {sub_addr, data} pairs. The sequencer issues one
// I2C write per pair through a req/busy handshake and reports done or error.
// Optional feature macro: I2C_RETRY_EN adds per-write NACK retries, up to
// MAX_RETRY. Without the macro, a NACK aborts at once.
//
// Handshake: req_trans is a registered request. It rises one cycle after the
// REQ state and stays high until the cycle in which i2c_busy=1 is sampled; it
// falls on that same edge. i2c_ack_err is sampled on the cycle that i2c_busy
// is seen low again. i_* are stable for as long as req_trans is high.
module i2c_cfg_sequencer #(
    parameter int                ADDR_W     = 6,
    parameter logic [ADDR_W-1:0] CFG_BASE   = 6'h10,
    parameter int                NUM_SLAVES = 2,
    parameter int                ROM_LAT    = 2,
    parameter int                BUSY_TMO   = 1023,
    parameter int                MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] rd_address,
    input  logic              i2c_busy,
    input  logic              i2c_ack_err,
    output logic              req_trans,
    output logic [7:0]        i_addr_w_rw,
    output logic [7:0]        i_sub_addr,
    output logic [7:0]        i_data_write,
    output logic              cfg_active,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic [1:0]        err_code,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_HDR_ADDR, S_HDR_CNT, S_SUB, S_DATA,
        S_REQ, S_WAIT_HI, S_WAIT_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state;
    state_t      target;     // state that consumes the byte once FETCH has waited out ROM latency
    logic [1:0]  lat_cnt;
    logic [3:0]  slave_cnt;
    logic [7:0]  pair_cnt;
    logic [9:0]  tmo_cnt;
    logic        nack;
    logic        last_slave;
`ifdef I2C_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_cnt;
`endif

    // The record currently being finished is the last one in the table
    assign last_slave = ((slave_cnt + 4'd1) == 4'(NUM_SLAVES));
    assign state_dbg  = state;

    // Sequencer FSM; all outputs are registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            target       <= S_HDR_ADDR;
            rd_address   <= CFG_BASE;
            lat_cnt      <= '0;
            slave_cnt    <= '0;
            pair_cnt     <= '0;
            tmo_cnt      <= '0;
            nack         <= 1'b0;
            req_trans    <= 1'b0;
            i_addr_w_rw  <= '0;
            i_sub_addr   <= '0;
            i_data_write <= '0;
            cfg_active   <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            err_code     <= 2'd0;
`ifdef I2C_RETRY_EN
            retry_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        cfg_done   <= 1'b0;
                        cfg_error  <= 1'b0;
                        err_code   <= 2'd0;
                        cfg_active <= 1'b1;
                        rd_address <= CFG_BASE;
                        slave_cnt  <= '0;
                        lat_cnt    <= '0;
                        target     <= S_HDR_ADDR;
                        state      <= S_FETCH;
`ifdef I2C_RETRY_EN
                        retry_cnt  <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (lat_cnt == 2'(ROM_LAT - 1)) begin
                        lat_cnt <= '0;
                        state   <= target;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_HDR_ADDR, S_HDR_CNT, S_SUB, S_DATA: begin
                    // Every byte consumer steps the address; stepping past the top is fatal
                    if (rd_address == '1) begin
                        state      <= S_ERROR;
                        cfg_error  <= 1'b1;
                        cfg_active <= 1'b0;
                        err_code   <= 2'd3;
                    end else begin
                        rd_address <= rd_address + ADDR_W'(1);
                        case (state)
                            S_HDR_ADDR: begin
                                i_addr_w_rw <= {rom_data[7:1], 1'b0};
                                target      <= S_HDR_CNT;
                                state       <= S_FETCH;
                            end
                            S_HDR_CNT: begin
                                pair_cnt <= rom_data;
                                if (rom_data == 8'd0) begin
                                    slave_cnt <= slave_cnt + 4'd1;
                                    if (last_slave) begin
                                        state      <= S_DONE;
                                        cfg_done   <= 1'b1;
                                        cfg_active <= 1'b0;
                                    end else begin
                                        target <= S_HDR_ADDR;
                                        state  <= S_FETCH;
                                    end
                                end else begin
                                    target <= S_SUB;
                                    state  <= S_FETCH;
                                end
                            end
                            S_SUB: begin
                                i_sub_addr <= rom_data;
                                target     <= S_DATA;
                                state      <= S_FETCH;
                            end
                            default: begin
                                i_data_write <= rom_data;
                                state        <= S_REQ;
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    req_trans <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i2c_busy) begin
                        req_trans <= 1'b0;
                        state     <= S_WAIT_LO;
                    end else if (tmo_cnt >= 10'(BUSY_TMO)) begin
                        req_trans  <= 1'b0;
                        state      <= S_ERROR;
                        cfg_error  <= 1'b1;
                        cfg_active <= 1'b0;
                        err_code   <= 2'd2;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (!i2c_busy) begin
                        nack  <= i2c_ack_err;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (nack) begin
`ifdef I2C_RETRY_EN
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= S_REQ;
                        end else begin
                            state      <= S_ERROR;
                            cfg_error  <= 1'b1;
                            cfg_active <= 1'b0;
                            err_code   <= 2'd1;
                        end
`else
                        state      <= S_ERROR;
                        cfg_error  <= 1'b1;
                        cfg_active <= 1'b0;
                        err_code   <= 2'd1;
`endif
                    end else begin
`ifdef I2C_RETRY_EN
                        retry_cnt <= '0;
`endif
                        pair_cnt <= pair_cnt - 8'd1;
                        lat_cnt  <= '0;
                        if (pair_cnt != 8'd1) begin
                            target <= S_SUB;
                            state  <= S_FETCH;
                        end else begin
                            slave_cnt <= slave_cnt + 4'd1;
                            if (last_slave) begin
                                state      <= S_DONE;
                                cfg_done   <= 1'b1;
                                cfg_active <= 1'b0;
                            end else begin
                                target <= S_HDR_ADDR;
                                state  <= S_FETCH;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: randomized bench for i2c_cfg_sequencer.
// A ROM model and an I2C master model surround the DUT. A table-walking
// reference model predicts the write stream, the final status and the final
// ROM address. Build with +define+I2C_RETRY_EN to cover the retry variant.
`timescale 1ns/1ps
module tb_i2c_cfg_sequencer;

    localparam int ADDR_W     = 6;
    localparam int CFG_BASE   = 16;
    localparam int NUM_SLAVES = 2;
    localparam int ROM_LAT    = 2;
    localparam int BUSY_TMO   = 1023;
    localparam int MAX_RETRY  = 3;
`ifdef I2C_RETRY_EN
    localparam int RETRIES = MAX_RETRY;
`else
    localparam int RETRIES = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        rom_data;
    logic [ADDR_W-1:0] rd_address;
    logic              i2c_busy;
    logic              i2c_ack_err;
    logic              req_trans;
    logic [7:0]        i_addr_w_rw, i_sub_addr, i_data_write;
    logic              cfg_active, cfg_done, cfg_error;
    logic [1:0]        err_code;
    logic [3:0]        state_dbg;

    i2c_cfg_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rom_data(rom_data),
        .rd_address(rd_address), .i2c_busy(i2c_busy), .i2c_ack_err(i2c_ack_err),
        .req_trans(req_trans), .i_addr_w_rw(i_addr_w_rw), .i_sub_addr(i_sub_addr),
        .i_data_write(i_data_write), .cfg_active(cfg_active), .cfg_done(cfg_done),
        .cfg_error(cfg_error), .err_code(err_code), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    int          checks = 0;
    int          errors = 0;
    logic [24:0] exp_q[$];          // {nack_to_return, addr, sub, data}
    logic [7:0]  mem [64];
    int          nack_plan [64];    // NACKs the master returns before ACKing write n
    int          exp_code, exp_rd, exp_total;
    int          req_pulses;
    bit          hang_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ROM with ROM_LAT cycles from address change to data
    logic [7:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= mem[rd_address];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // I2C master model: accepts requests, compares against the expected stream
    initial begin
        int dly, hold;
        logic [24:0] e;
        i2c_busy    = 1'b0;
        i2c_ack_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (req_trans && reset_n && !hang_busy) begin
                dly = $urandom_range(0, 3);
                for (int k = 0; k < dly; k++) begin @(posedge clk); #1; end
                if (req_trans && reset_n) begin
                    req_pulses++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                        e = '0;
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {i_addr_w_rw, i_sub_addr, i_data_write}, {8'h0, e[23:0]});
                    end
                    i2c_busy = 1'b1;
                    hold = $urandom_range(2, 5);
                    for (int k = 0; k < hold; k++) begin @(posedge clk); #1; end
                    i2c_busy    = 1'b0;
                    i2c_ack_err = e[24];
                end
            end
        end
    end

    // Request fields must not move while a request is pending
    logic        prev_req = 1'b0;
    logic [23:0] prev_io;
    always @(negedge clk) begin
        if (reset_n && req_trans && prev_req)
            check("io_stable", {i_addr_w_rw, i_sub_addr, i_data_write}, prev_io);
        prev_req = req_trans && reset_n;
        prev_io  = {i_addr_w_rw, i_sub_addr, i_data_write};
    end

    // Reference model: walk the table from CFG_BASE by the record rules
    task automatic build_model();
        int ptr, cnt, n, w, att;
        logic [7:0] a, sa, d;
        exp_q.delete();
        ptr = CFG_BASE; exp_code = 0; w = 0; exp_total = 0;
        for (int s = 0; s < NUM_SLAVES && exp_code == 0; s++) begin
            cnt = 0;
            a = mem[ptr];
            if (ptr == 63) exp_code = 3; else ptr++;
            if (exp_code == 0) begin
                cnt = mem[ptr];
                if (ptr == 63) exp_code = 3; else ptr++;
            end
            for (int p = 0; p < cnt && exp_code == 0; p++) begin
                sa = mem[ptr];
                if (ptr == 63) exp_code = 3; else ptr++;
                if (exp_code == 0) begin
                    d = mem[ptr];
                    if (ptr == 63) exp_code = 3; else ptr++;
                end
                if (exp_code == 0) begin
                    n = nack_plan[w]; w++;
                    att = (n > RETRIES) ? RETRIES + 1 : n + 1;
                    for (int k = 0; k < att; k++) begin
                        exp_q.push_back({(k < n), a[7:1], 1'b0, sa, d});
                        exp_total++;
                    end
                    if (n > RETRIES) exp_code = 1;
                end
            end
        end
        exp_rd = ptr;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // Start the table, optionally re-pulse start mid-run, then check the outcome
    task automatic run_cfg(input string name, input int budget, input int poke);
        int cyc;
        build_model();
        req_pulses = 0;
        pulse_start();
        cyc = 0;
        while (!(cfg_done || cfg_error) && cyc < budget) begin
            check({name, "_active"}, cfg_active, 1'b1);
            start = (cyc == poke);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({name, "_finished"}, (cyc < budget), 1'b1);
        check({name, "_done"}, cfg_done, (exp_code == 0));
        check({name, "_error"}, cfg_error, (exp_code != 0));
        check({name, "_err_code"}, err_code, exp_code);
        check({name, "_rd_address"}, rd_address, exp_rd);
        check({name, "_req_pulses"}, req_pulses, exp_total);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_idle_out"}, {cfg_active, req_trans}, 2'b00);
    endtask

    task automatic load_t1();
        logic [7:0] t [10] = '{8'hB8, 8'd2, 8'h03, 8'h0D, 8'h0F, 8'h02, 8'h5A, 8'd1, 8'h01, 8'h80};
        for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 10; i++) mem[CFG_BASE + i] = t[i];
        for (int i = 0; i < 64; i++) nack_plan[i] = 0;
    endtask

    task automatic load_random();
        int ptr, cnt;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        ptr = CFG_BASE;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            cnt = $urandom_range(0, 4);
            mem[ptr+1] = 8'(cnt);
            ptr += 2 + 2 * cnt;
        end
        for (int i = 0; i < 64; i++)
            nack_plan[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd"}, rd_address, CFG_BASE);
        check({name, "_req"}, req_trans, 1'b0);
        check({name, "_io"}, {i_addr_w_rw, i_sub_addr, i_data_write}, 24'h0);
        check({name, "_flags"}, {cfg_active, cfg_done, cfg_error, err_code}, 5'b0);
    endtask

    initial begin
        int cyc, hi;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 64; i++) begin mem[i] = 8'h00; nack_plan[i] = 0; end
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        reset_n = 1'b1;

        // T1: three writes in table order
        load_t1();
        run_cfg("t1", 2000, -1);

        // T2: first slave has no pairs
        load_t1();
        mem[CFG_BASE]   = 8'h22; mem[CFG_BASE+1] = 8'd0;
        mem[CFG_BASE+2] = 8'h5A; mem[CFG_BASE+3] = 8'd1;
        mem[CFG_BASE+4] = 8'h01; mem[CFG_BASE+5] = 8'h80;
        run_cfg("t2", 2000, -1);

        // T3: NACKs on the second write
        load_t1();
        nack_plan[1] = 1;
        run_cfg("t3_nack1", 2000, -1);
        nack_plan[1] = 2;
        run_cfg("t3_nack2", 2000, -1);
        nack_plan[1] = 4;
        run_cfg("t3_nack4", 2000, -1);

        // Randomized tables, data and NACK patterns
        for (int it = 0; it < 20; it++) begin
            load_random();
            run_cfg("rand", 3000, -1);
        end

        // T4: busy never rises
        load_t1();
        build_model();
        hang_busy = 1'b1;
        pulse_start();
        cyc = 0; hi = 0;
        while (!cfg_error && cyc < 1500) begin
            @(negedge clk);
            if (req_trans) hi++;
            cyc++;
        end
        check("t4_finished", (cyc < 1500), 1'b1);
        check("t4_error", {cfg_error, cfg_done}, 2'b10);
        check("t4_err_code", err_code, 2'd2);
        check("t4_req_low", req_trans, 1'b0);
        check("t4_req_cycles", (hi >= BUSY_TMO && hi <= BUSY_TMO + 2), 1'b1);
        check("t4_rd_address", rd_address, CFG_BASE + 4);
        hang_busy = 1'b0;
        exp_q.delete();

        // T5: reset while the master is still busy, then rerun T1
        load_t1();
        build_model();
        pulse_start();
        cyc = 0;
        while (!(i2c_busy && !req_trans) && cyc < 500) begin @(posedge clk); #1; cyc++; end
        check("t5_reached_wait_lo", (cyc < 500), 1'b1);
        reset_n = 1'b0;
        #2 check_reset_outputs("t5_async");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("t5_reset");
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        exp_q.delete();
        run_cfg("t5_rerun", 2000, -1);

        // T6: table runs into the top of the ROM; a start mid-run is ignored
        for (int i = 0; i < 64; i++) begin mem[i] = 8'($urandom_range(0, 255)); nack_plan[i] = 0; end
        mem[CFG_BASE+1] = 8'd24;
        run_cfg("t6_overrun", 4000, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "bench timeout");
    end

endmodule
